// File: rtl/fetch_stage_pkg.sv
// Shared cpu constants for the 16-bit pipeline.
// Word width, fetch FSM encoding and default fetch values.
package fetch_stage_pkg;

  localparam int unsigned XLEN = 16;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t      DEF_RESET_PC   = 16'h0000;
  localparam word_t      DEF_NOP_INST   = 16'h0000;
  localparam logic [3:0] DEF_HLT_OPCODE = 4'hF;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  function automatic logic is_hlt(
    input word_t      w,
    input logic [3:0] op
  );
    return w[XLEN-1:XLEN-4] == op;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, PC+2 and valid.
// Reset clears all fields; flush wins over hold and keeps pc_plus2.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter word_t NOP_INST = DEF_NOP_INST
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  hold,
  input  word_t inst_in,
  input  word_t pc_plus2_in,
  output word_t instruction,
  output word_t pc_plus2,
  output logic  valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= NOP_INST;
      pc_plus2    <= '0;
      valid       <= 1'b0;
    end else if (flush) begin
      instruction <= NOP_INST;
      valid       <= 1'b0;
    end else if (!hold) begin
      instruction <= inst_in;
      pc_plus2    <= pc_plus2_in;
      valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, run/halt FSM and IF/ID register.
// Priority per edge: rst > redirect_D > stall_F > FSM action.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t      RESET_PC   = DEF_RESET_PC,
  parameter word_t      NOP_INST   = DEF_NOP_INST,
  parameter logic [3:0] HLT_OPCODE = DEF_HLT_OPCODE
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  stall_F,
  input  logic  redirect_D,
  input  word_t redirect_pc_D,
  input  word_t imem_data,
  output word_t imem_addr,
  output word_t pc,
  output word_t instruction,
  output word_t pc_plus2_D,
  output logic  valid_D,
  output logic  halted_F
);

  logic [0:0] state;
  word_t      pc_next_seq;
  logic       hlt_seen;
  logic       flush;

  assign pc_next_seq = pc + 16'd2;
  assign hlt_seen    = is_hlt(imem_data, HLT_OPCODE);
  assign imem_addr   = pc;
  assign halted_F    = (state == ST_HALTED);

  // A halted stage keeps squashing IF/ID until a redirect arrives.
  assign flush = redirect_D | (!stall_F && state == ST_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else if (redirect_D) begin
      pc    <= redirect_pc_D;
      state <= ST_RUN;
    end else if (!stall_F && state == ST_RUN) begin
      if (hlt_seen) state <= ST_HALTED;
      else          pc    <= pc_next_seq;
    end
  end

  if_id_reg #(
    .NOP_INST(NOP_INST)
  ) u_if_id (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .hold        (stall_F),
    .inst_in     (imem_data),
    .pc_plus2_in (pc_next_seq),
    .instruction (instruction),
    .pc_plus2    (pc_plus2_D),
    .valid       (valid_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Small imem model; checks after each edge with assertions.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_F;
  logic        redirect_D;
  logic [15:0] redirect_pc_D;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] pc;
  logic [15:0] instruction;
  logic [15:0] pc_plus2_D;
  logic        valid_D;
  logic        halted_F;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall_F       (stall_F),
    .redirect_D    (redirect_D),
    .redirect_pc_D (redirect_pc_D),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .pc            (pc),
    .instruction   (instruction),
    .pc_plus2_D    (pc_plus2_D),
    .valid_D       (valid_D),
    .halted_F      (halted_F)
  );

  // Few named words, everything else reads as opcode 1 plus low address bits.
  always_comb begin
    imem_data = {4'h1, imem_addr[11:0]};
    case (imem_addr)
      16'h0000: imem_data = 16'h1234;
      16'h0002: imem_data = 16'h2345;
      16'h0004: imem_data = 16'h3456;
      16'h000A: imem_data = 16'hF000;
      16'hFFFE: imem_data = 16'h7777;
      default:  ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_pc,
                         input logic [15:0] e_inst, input logic e_v,
                         input logic e_h);
    chk({tag, ".pc"}, pc, e_pc);
    chk({tag, ".addr"}, imem_addr, e_pc);
    chk({tag, ".inst"}, instruction, e_inst);
    chk({tag, ".valid"}, {15'd0, valid_D}, {15'd0, e_v});
    chk({tag, ".halted"}, {15'd0, halted_F}, {15'd0, e_h});
  endtask

  initial begin
    rst = 1'b1;
    stall_F = 1'b0;
    redirect_D = 1'b0;
    redirect_pc_D = 16'h0000;

    // reset for two cycles
    tick();
    chk_all("rst1", 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("rst1.pp2", pc_plus2_D, 16'h0000);
    tick();
    rst = 1'b0;
    chk_all("rst2", 16'h0000, 16'h0000, 1'b0, 1'b0);

    // straight-line fetch
    tick();
    chk_all("seq1", 16'h0002, 16'h1234, 1'b1, 1'b0);
    chk("seq1.pp2", pc_plus2_D, 16'h0002);
    tick();
    chk_all("seq2", 16'h0004, 16'h2345, 1'b1, 1'b0);
    chk("seq2.pp2", pc_plus2_D, 16'h0004);

    // stall two cycles at pc=4
    stall_F = 1'b1;
    tick();
    chk_all("stl1", 16'h0004, 16'h2345, 1'b1, 1'b0);
    tick();
    chk_all("stl2", 16'h0004, 16'h2345, 1'b1, 1'b0);
    chk("stl2.pp2", pc_plus2_D, 16'h0004);
    stall_F = 1'b0;
    tick();
    chk_all("seq3", 16'h0006, 16'h3456, 1'b1, 1'b0);
    chk("seq3.pp2", pc_plus2_D, 16'h0006);
    tick();
    chk_all("seq4", 16'h0008, 16'h1006, 1'b1, 1'b0);

    // redirect with simultaneous stall at pc=8
    redirect_D = 1'b1;
    redirect_pc_D = 16'h0040;
    stall_F = 1'b1;
    tick();
    chk_all("rds1", 16'h0040, 16'h0000, 1'b0, 1'b0);
    redirect_D = 1'b0;
    stall_F = 1'b0;
    tick();
    chk_all("rds2", 16'h0042, 16'h1040, 1'b1, 1'b0);
    chk("rds2.pp2", pc_plus2_D, 16'h0042);

    // jump to the HLT word
    redirect_D = 1'b1;
    redirect_pc_D = 16'h000A;
    tick();
    chk_all("rdh", 16'h000A, 16'h0000, 1'b0, 1'b0);
    redirect_D = 1'b0;
    tick();
    chk_all("hlt1", 16'h000A, 16'hF000, 1'b1, 1'b1);
    chk("hlt1.pp2", pc_plus2_D, 16'h000C);
    tick();
    chk_all("hlt2", 16'h000A, 16'h0000, 1'b0, 1'b1);
    tick();
    chk_all("hlt3", 16'h000A, 16'h0000, 1'b0, 1'b1);

    // wrong-path halt recovery
    redirect_D = 1'b1;
    redirect_pc_D = 16'h0020;
    tick();
    chk_all("rec1", 16'h0020, 16'h0000, 1'b0, 1'b0);
    redirect_D = 1'b0;
    tick();
    chk_all("rec2", 16'h0022, 16'h1020, 1'b1, 1'b0);

    // PC wrap at 16'hFFFE
    redirect_D = 1'b1;
    redirect_pc_D = 16'hFFFE;
    tick();
    chk_all("wrp1", 16'hFFFE, 16'h0000, 1'b0, 1'b0);
    redirect_D = 1'b0;
    tick();
    chk_all("wrp2", 16'h0000, 16'h7777, 1'b1, 1'b0);
    chk("wrp2.pp2", pc_plus2_D, 16'h0000);
    tick();
    chk_all("wrp3", 16'h0002, 16'h1234, 1'b1, 1'b0);

    // halt again, then reset while halted
    redirect_D = 1'b1;
    redirect_pc_D = 16'h000A;
    tick();
    redirect_D = 1'b0;
    tick();
    chk_all("hlt4", 16'h000A, 16'hF000, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    chk_all("rsth", 16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("rsth.pp2", pc_plus2_D, 16'h0000);
    rst = 1'b0;
    tick();
    chk_all("post", 16'h0002, 16'h1234, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
